alu_exec_stage: RTL and testbench

- Execute stage of the 32-bit processor datapath. It sits between the decode/operand-fetch stage and writeback, and consumes operandA/operandB plus an opcode.
- Produces a registered result. Logic ops use the bitwise gate-level units; ADD/SUB/SLT use an adder.
- Shifts run on an iterative one-bit-per-cycle shifter.
- Valid/ready handshake on both sides, with a single-entry registered output.

---
 rtl/alu_exec_stage.sv | 174 +++++++++++++++++
 tb/tb_alu_exec_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage: AND/OR/ADD/SUB/SLT in one cycle, shifts on an iterative
// one-bit-per-cycle shifter, single registered result slot toward writeback.
module alu_exec_stage #(
    parameter int WIDTH       = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             o_dbg_state
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    localparam logic [1:0] KIND_SLL = 2'b01;
    localparam logic [1:0] KIND_SRL = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_shreg;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic [1:0]             r_kind;
    logic [WIDTH-1:0]       r_result;
    logic                   r_overflow;
    logic                   r_zero;
    logic                   r_out_valid;

    state_t                 w_next_state;
    logic [WIDTH-1:0]       w_next_shreg;
    logic [SHAMT_WIDTH-1:0] w_next_cnt;
    logic [1:0]             w_next_kind;
    logic [WIDTH-1:0]       w_next_result;
    logic                   w_next_overflow;
    logic                   w_next_zero;
    logic                   w_next_out_valid;

    logic                   w_accept;
    logic                   w_is_shift;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic                   w_use_sub;
    logic [WIDTH-1:0]       w_b_eff;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_add_ovf;
    logic                   w_lt;
    logic [WIDTH-1:0]       w_alu_result;
    logic                   w_alu_ovf;
    logic [WIDTH-1:0]       w_shift_step;

    // Handshake: an op is taken on in_valid && in_ready; a result leaves on
    // out_valid && out_ready. in_ready is combinational on out_ready so a
    // draining result and a new op can share one edge.
    assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;

    assign w_is_shift  = opcode[2] && (opcode[1] || opcode[0]);
    assign w_shamt     = operandB[SHAMT_WIDTH-1:0];

    // One adder serves ADD, SUB and SLT; subtraction is A + ~B + 1.
    assign w_use_sub   = (opcode == OP_SUB) || (opcode == OP_SLT);
    assign w_b_eff     = w_use_sub ? ~operandB : operandB;
    assign w_sum       = operandA + w_b_eff + {{(WIDTH-1){1'b0}}, w_use_sub};
    assign w_add_ovf   = (operandA[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != operandA[WIDTH-1]);
    assign w_lt        = w_sum[WIDTH-1] ^ w_add_ovf;
    assign w_alu_ovf   = ((opcode == OP_ADD) || (opcode == OP_SUB)) && w_add_ovf;

    always_comb begin
        w_alu_result = operandA;
        case (opcode)
            OP_AND:  w_alu_result = operandA & operandB;
            OP_OR:   w_alu_result = operandA | operandB;
            OP_ADD:  w_alu_result = w_sum;
            OP_SUB:  w_alu_result = w_sum;
            OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: w_alu_result = operandA;
        endcase
    end

    always_comb begin
        w_shift_step = r_shreg;
        case (r_kind)
            KIND_SLL: w_shift_step = {r_shreg[WIDTH-2:0], 1'b0};
            KIND_SRL: w_shift_step = {1'b0, r_shreg[WIDTH-1:1]};
            default:  w_shift_step = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_shreg     = r_shreg;
        w_next_cnt       = r_cnt;
        w_next_kind      = r_kind;
        w_next_result    = r_result;
        w_next_overflow  = r_overflow;
        w_next_zero      = r_zero;
        w_next_out_valid = r_out_valid && !out_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_next_shreg = operandA;
                        w_next_cnt   = w_shamt;
                        w_next_kind  = opcode[1:0];
                        w_next_state = ST_SHIFT;
                    end else begin
                        w_next_result    = w_alu_result;
                        w_next_overflow  = w_alu_ovf;
                        w_next_zero      = (w_alu_result == '0);
                        w_next_out_valid = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                w_next_shreg = w_shift_step;
                w_next_cnt   = r_cnt - SHAMT_WIDTH'(1);
                // out_valid is already low here, so completion cannot clobber a result.
                if (r_cnt == SHAMT_WIDTH'(1)) begin
                    w_next_result    = w_shift_step;
                    w_next_overflow  = 1'b0;
                    w_next_zero      = (w_shift_step == '0);
                    w_next_out_valid = 1'b1;
                    w_next_state     = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_kind      <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_shreg     <= w_next_shreg;
            r_cnt       <= w_next_cnt;
            r_kind      <= w_next_kind;
            r_result    <= w_next_result;
            r_overflow  <= w_next_overflow;
            r_zero      <= w_next_zero;
            r_out_valid <= w_next_out_valid;
        end
    end

    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign overflow    = r_overflow;
    assign zero        = r_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed timing cases plus a randomized run
// scored against an arithmetic reference model through an expected queue.
module tb_alu_exec_stage;
    localparam int W  = 32;
    localparam int EW = W + 2;

    logic         clock     = 1'b0;
    logic         reset_n   = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [2:0]   opcode    = 3'd0;
    logic [W-1:0] operandA  = '0;
    logic [W-1:0] operandB  = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;
    logic         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic          rand_bp = 1'b0;

    alu_exec_stage #(.WIDTH(W), .SHAMT_WIDTH(5)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .operandA   (operandA),
        .operandB   (operandB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .zero       (zero),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: {overflow, zero, result} from plain signed arithmetic.
    function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s  = 0;
        int     sh = int'(b[4:0]);
        logic [W-1:0] r;
        logic ov = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                s  = sa + sb;
                r  = W'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd3: begin
                s  = sa - sb;
                r  = W'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: r = $unsigned($signed(a) >>> sh);
        endcase
        return {ov, (r == '0), r};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("sb_result", result, mon_e[W-1:0]);
                check("sb_overflow", 32'(overflow), 32'(mon_e[EW-1]));
                check("sb_zero", 32'(zero), 32'(mon_e[W]));
            end
        end
    end

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after posedge; everything is sampled on negedge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int waits);
        in_valid = 1'b1;
        opcode   = op;
        operandA = a;
        operandB = b;
        waits    = 0;
        while (1) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(model(op, a, b));
                break;
            end
            waits++;
            if (waits >= 200) begin
                check("send_accept_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int w;
        int cnt;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        // OR, one-cycle latency
        send(3'd1, 32'hF0F0_0000, 32'h0000_0F0F, w);
        idle_in();
        check("or_wait", 32'(w), 32'd0);
        @(negedge clock);
        check("or_valid", 32'(out_valid), 32'd1);
        check("or_result", result, 32'hF0F0_0F0F);
        check("or_zero", 32'(zero), 32'd0);
        check("or_overflow", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;

        // ADD then SUB back to back
        send(3'd2, 32'h7FFF_FFFF, 32'h0000_0001, w);
        check("add_wait", 32'(w), 32'd0);
        check("add_result", result, 32'h8000_0000);
        check("add_overflow", 32'(overflow), 32'd1);
        send(3'd3, 32'd5, 32'd5, w);
        idle_in();
        check("sub_wait", 32'(w), 32'd0);
        @(negedge clock);
        check("sub_result", result, 32'd0);
        check("sub_zero", 32'(zero), 32'd1);
        check("sub_overflow", 32'(overflow), 32'd0);
        @(posedge clock);
        #1;

        // SRA by 4: four busy cycles, result on the fifth
        send(3'd7, 32'h8000_0010, 32'd4, w);
        idle_in();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (i <= 4) begin
                check("sra_busy_in_ready", 32'(in_ready), 32'd0);
                check("sra_busy_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("sra_done_valid", 32'(out_valid), 32'd1);
                check("sra_result", result, 32'hF800_0001);
            end
        end
        @(posedge clock);
        #1;

        // Shift by zero (upper amount bits ignored)
        send(3'd5, 32'h1234_5678, 32'h0000_0020, w);
        idle_in();
        @(negedge clock);
        check("sll0_valid", 32'(out_valid), 32'd1);
        check("sll0_result", result, 32'h1234_5678);
        @(posedge clock);
        #1;

        // Backpressure after SLT(-1, 1)
        out_ready = 1'b0;
        send(3'd4, 32'hFFFF_FFFF, 32'd1, w);
        in_valid = 1'b1;
        opcode   = 3'd0;
        operandA = 32'hFF00_FF00;
        operandB = 32'h0F0F_0F0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", result, 32'd1);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(3'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, w);
        idle_in();
        check("bp_release_wait", 32'(w), 32'd0);
        @(negedge clock);
        check("bp_and_result", result, 32'h0F00_0F00);
        @(posedge clock);
        #1;

        // Reset in the middle of SLL by 20
        send(3'd5, 32'h0000_0001, 32'd20, w);
        idle_in();
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clock);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_state_after", 32'(dbg_state), 32'd0);
        cnt = 0;
        repeat (25) begin
            @(negedge clock);
            if (out_valid) cnt++;
        end
        check("abort_no_result", 32'(cnt), 32'd0);
        @(posedge clock);
        #1;

        // Randomized run with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h7FFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(0, 3));
                1:       b = a;
                default: b = $urandom;
            endcase
            send(op, a, b, w);
            if ($urandom_range(0, 3) == 0) begin
                idle_in();
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
        idle_in();
        rand_bp = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 500) begin
            @(negedge clock);
            cnt++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
